// File: rtl/flash_word_reader_if.sv
// Controller-side port bundle of flash_word_reader: read request in, assembled word out.
interface flash_word_reader_if #(
    parameter int ADDR_W = 21
);
    logic              i_start;
    logic [ADDR_W-1:0] i_top_addr;
    logic [31:0]       o_data_out;
    logic              o_ack;
    logic              o_busy;

    // Handshake: i_start with i_top_addr is taken only while o_busy is low; each accepted
    // request is answered by exactly one single-cycle o_ack, o_data_out valid in that cycle.
    modport master (output i_start, output i_top_addr,
                    input  o_data_out, input o_ack, input o_busy);
    modport slave  (input  i_start, input i_top_addr,
                    output o_data_out, output o_ack, output o_busy);
endinterface

// File: rtl/flash_word_reader.sv
// Reads four consecutive bytes from an 8-bit parallel NOR flash and returns them as one word.
// Optional last-word cache enabled by defining FLASH_READ_CACHE_EN.
module flash_word_reader #(
    parameter int WAIT_CYCLES = 4,
    parameter int ADDR_W      = 21
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    flash_word_reader_if.slave  bus,
    input  logic [7:0]          i_data_in,
    output logic [ADDR_W+1:0]   o_addr,
    output logic                o_ce_n,
    output logic                o_oe_n,
    output logic                o_we_n,
    output logic                o_rst_n,
    output logic                o_wp_n,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt;
    logic [1:0]          r_k;
    logic [1:0]          w_k;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr;
    logic [31:0]         r_data;
    logic [31:0]         w_data;
    logic [ADDR_W+1:0]   r_faddr;
    logic [ADDR_W+1:0]   w_faddr;
    logic                r_ack;
    logic                r_busy;
    logic                r_ce_n;
    logic                w_hit;
    logic [31:0]         w_cache_data;

`ifdef FLASH_READ_CACHE_EN
    logic                r_cache_valid;
    logic [ADDR_W-1:0]   r_cache_addr;
    logic [31:0]         r_cache_data;

    // Refilled on every completed read, hits included, so it always holds the last word returned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cache_valid <= 1'b0;
            r_cache_addr  <= '0;
            r_cache_data  <= '0;
        end else if (r_state == S_DONE) begin
            r_cache_valid <= 1'b1;
            r_cache_addr  <= r_addr;
            r_cache_data  <= r_data;
        end
    end

    assign w_hit        = r_cache_valid && (bus.i_top_addr == r_cache_addr);
    assign w_cache_data = r_cache_data;
`else
    assign w_hit        = 1'b0;
    assign w_cache_data = '0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_k     = r_k;
        w_addr  = r_addr;
        w_data  = r_data;
        w_faddr = r_faddr;
        case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_addr = bus.i_top_addr;
                    if (w_hit) begin
                        w_state = S_DONE;
                        w_data  = w_cache_data;
                    end else begin
                        w_state = S_ACCESS;
                        w_k     = 2'd0;
                        w_cnt   = '0;
                        w_faddr = {bus.i_top_addr, 2'b00};
                    end
                end
            end
            S_ACCESS: begin
                w_cnt = r_cnt + 1'b1;
                // Last cycle of the byte window: flash access time has elapsed, take the bus.
                if (r_cnt == CNT_LAST) begin
                    w_cnt = '0;
                    w_data[{r_k, 3'b000} +: 8] = i_data_in;
                    if (r_k == 2'd3) begin
                        w_state = S_DONE;
                    end else begin
                        w_k     = r_k + 2'd1;
                        w_faddr = {r_addr, r_k + 2'd1};
                    end
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so every pin changes right on the clock edge.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_k     <= 2'd0;
            r_addr  <= '0;
            r_data  <= '0;
            r_faddr <= '0;
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_ce_n  <= 1'b1;
        end else begin
            r_cnt   <= w_cnt;
            r_k     <= w_k;
            r_addr  <= w_addr;
            r_data  <= w_data;
            r_faddr <= w_faddr;
            r_ack   <= (w_state == S_DONE);
            r_busy  <= (w_state != S_IDLE);
            r_ce_n  <= (w_state != S_ACCESS);
        end
    end

    assign bus.o_data_out = r_data;
    assign bus.o_ack      = r_ack;
    assign bus.o_busy     = r_busy;
    assign o_addr         = r_faddr;
    assign o_ce_n         = r_ce_n;
    assign o_oe_n         = r_ce_n;
    assign o_we_n         = 1'b1;
    assign o_rst_n        = 1'b1;
    assign o_wp_n         = 1'b1;
    assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_flash_word_reader.sv
// Bench for flash_word_reader: three instances (WAIT_CYCLES 4, 1, 7) share one request stream,
// each with its own flash model that only returns valid data at the end of the access time.
module tb_flash_word_reader;
    localparam int ADDR_W = 21;
    localparam int NDUT   = 3;
`ifdef FLASH_READ_CACHE_EN
    localparam bit CACHE = 1'b1;
`else
    localparam bit CACHE = 1'b0;
`endif

    function automatic int wof(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            default: return 7;
        endcase
    endfunction

    // Flash contents: fixed test pattern at 0x10..0x13, seeded hash elsewhere.
    function automatic logic [7:0] flash_byte(input logic [22:0] a, input logic [7:0] s);
        logic [7:0] lo;
        if (a >= 23'h10 && a <= 23'h13) return 8'h11 * (a[7:0] - 8'h0F);
        lo = a[7:0];
        return (lo * 8'd37) ^ a[15:8] ^ {1'b0, a[22:16]} ^ s;
    endfunction

    function automatic logic [31:0] exp_word(input logic [20:0] a, input logic [7:0] s);
        return {flash_byte({a, 2'd3}, s), flash_byte({a, 2'd2}, s),
                flash_byte({a, 2'd1}, s), flash_byte({a, 2'd0}, s)};
    endfunction

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] top = '0;
    logic [7:0]        seed = 8'h00;

    logic              ack_v  [NDUT];
    logic              busy_v [NDUT];
    logic              ce_v   [NDUT];
    logic              oe_v   [NDUT];
    logic              we_v   [NDUT];
    logic              frst_v [NDUT];
    logic              wp_v   [NDUT];
    logic [31:0]       data_v [NDUT];
    logic [22:0]       addr_v [NDUT];
    logic [1:0]        dbg_v  [NDUT];
    logic [1:0]        idle_dbg [NDUT];

    int                checks = 0;
    int                errors = 0;
    bit                cache_valid = 1'b0;
    logic [ADDR_W-1:0] cache_addr = '0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int W = wof(g);
        flash_word_reader_if #(.ADDR_W(ADDR_W)) bus ();
        logic [7:0]  dq;
        logic [22:0] addr;
        logic        ce_n, oe_n, we_n, frst_n, wp_n;
        logic [1:0]  dbg;
        logic [22:0] prev_addr = '0;
        logic        prev_ce_n = 1'b1;
        int          age_q = 0;
        int          age;

        assign bus.i_start    = start;
        assign bus.i_top_addr = top;

        flash_word_reader #(.WAIT_CYCLES(W), .ADDR_W(ADDR_W)) u_dut (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .bus        (bus),
            .i_data_in  (dq),
            .o_addr     (addr),
            .o_ce_n     (ce_n),
            .o_oe_n     (oe_n),
            .o_we_n     (we_n),
            .o_rst_n    (frst_n),
            .o_wp_n     (wp_n),
            .o_dbg_state(dbg)
        );

        // age = completed cycles the current address has been driven with the chip enabled.
        always_comb age = (addr != prev_addr || ce_n || prev_ce_n) ? 0 : age_q + 1;
        always @(posedge clk) begin
            prev_addr <= addr;
            prev_ce_n <= ce_n;
            age_q     <= age;
        end
        assign dq = (age == W - 1) ? flash_byte(addr, seed) : (flash_byte(addr, seed) ^ 8'hA5);

        assign ack_v[g]  = bus.o_ack;
        assign busy_v[g] = bus.o_busy;
        assign data_v[g] = bus.o_data_out;
        assign addr_v[g] = addr;
        assign ce_v[g]   = ce_n;
        assign oe_v[g]   = oe_n;
        assign we_v[g]   = we_n;
        assign frst_v[g] = frst_n;
        assign wp_v[g]   = wp_n;
        assign dbg_v[g]  = dbg;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals(input string where);
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("%s_data_d%0d", where, d), data_v[d], 32'h0);
            chk($sformatf("%s_ack_d%0d", where, d), ack_v[d], 1'b0);
            chk($sformatf("%s_busy_d%0d", where, d), busy_v[d], 1'b0);
            chk($sformatf("%s_addr_d%0d", where, d), addr_v[d], 23'h0);
            chk($sformatf("%s_ce_d%0d", where, d), ce_v[d], 1'b1);
            chk($sformatf("%s_oe_d%0d", where, d), oe_v[d], 1'b1);
            chk($sformatf("%s_we_d%0d", where, d), we_v[d], 1'b1);
            chk($sformatf("%s_frst_d%0d", where, d), frst_v[d], 1'b1);
            chk($sformatf("%s_wp_d%0d", where, d), wp_v[d], 1'b1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        cache_valid = 1'b0;
    endtask

    // One request pulse, then 32 cycles of per-cycle checks against the timing rules.
    task automatic do_read(input logic [ADDR_W-1:0] a);
        int          exp_ack [NDUT];
        bit          hit;
        logic [31:0] w;
        hit = CACHE && cache_valid && (cache_addr == a);
        w   = exp_word(a, seed);
        for (int d = 0; d < NDUT; d++) exp_ack[d] = hit ? 1 : 1 + 4 * wof(d);
        @(negedge clk);
        start = 1'b1;
        top   = a;
        @(negedge clk);
        start = 1'b0;
        top   = ADDR_W'($urandom);
        for (int n = 1; n <= 32; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                bit in_acc;
                in_acc = !hit && (n <= 4 * wof(d));
                chk($sformatf("ack_a%0h_d%0d_c%0d", a, d, n), ack_v[d], n == exp_ack[d]);
                chk($sformatf("busy_a%0h_d%0d_c%0d", a, d, n), busy_v[d], n <= exp_ack[d]);
                chk($sformatf("ce_a%0h_d%0d_c%0d", a, d, n), ce_v[d], !in_acc);
                chk($sformatf("oe_a%0h_d%0d_c%0d", a, d, n), oe_v[d], !in_acc);
                if (in_acc)
                    chk($sformatf("addr_a%0h_d%0d_c%0d", a, d, n), addr_v[d],
                        {a, 2'b00} + 23'((n - 1) / wof(d)));
                if (n >= exp_ack[d])
                    chk($sformatf("data_a%0h_d%0d_c%0d", a, d, n), data_v[d], w);
                if (n == 1 && !hit)
                    chk($sformatf("dbg_busy_d%0d", d), dbg_v[d] != idle_dbg[d], 1'b1);
                if (n == 32)
                    chk($sformatf("dbg_idle_d%0d", d), dbg_v[d] == idle_dbg[d], 1'b1);
            end
            @(negedge clk);
        end
        cache_valid = 1'b1;
        cache_addr  = a;
    endtask

    initial begin
        int          exp_q  [NDUT][$];
        logic [31:0] word_q [NDUT][$];
        seed = 8'($urandom);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("init");
        for (int d = 0; d < NDUT; d++) idle_dbg[d] = dbg_v[d];
        rst_n = 1'b1;

        // Basic read: bytes 0x11..0x44 at 0x10..0x13.
        do_read(21'h4);
        chk("basic_word", data_v[0], 32'h44332211);

        for (int i = 0; i < 3; i++) do_read(ADDR_W'($urandom));

        // Back-to-back with start held high: first request 0x0, then 0x1.
        for (int d = 0; d < NDUT; d++) begin
            int t, lat, nacc;
            bit cv;
            logic [ADDR_W-1:0] ca, x;
            t = 0; nacc = 0; cv = 1'b0; ca = '0;
            while (t <= 39) begin
                x   = (nacc == 0) ? ADDR_W'(0) : ADDR_W'(1);
                lat = (CACHE && cv && ca == x) ? 1 : 1 + 4 * wof(d);
                exp_q[d].push_back(t + lat);
                word_q[d].push_back(exp_word(x, seed));
                cv = 1'b1; ca = x;
                t = t + lat + 1;
                nacc++;
            end
        end
        @(negedge clk);
        start = 1'b1;
        top   = 21'h0;
        @(negedge clk);
        top   = 21'h1;
        for (int n = 1; n <= 40; n++) begin
            for (int d = 0; d < NDUT; d++) begin
                bit exp_ack;
                exp_ack = (exp_q[d].size() > 0) && (exp_q[d][0] == n);
                chk($sformatf("b2b_ack_d%0d_c%0d", d, n), ack_v[d], exp_ack);
                if (exp_ack) begin
                    void'(exp_q[d].pop_front());
                    chk($sformatf("b2b_data_d%0d_c%0d", d, n), data_v[d], word_q[d].pop_front());
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        do_reset();

        // Top of the address space: byte addresses 0x7FFFFC..0x7FFFFF.
        do_read(21'h1FFFFF);
        chk("max_last_addr", addr_v[0], 23'h7FFFFF);

        // Reset in cycle 9 of a read.
        @(negedge clk);
        start = 1'b1;
        top   = 21'h2A;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        chk("mid_ce_low_d0", ce_v[0], 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        cache_valid = 1'b0;
        for (int n = 0; n < 30; n++) begin
            for (int d = 0; d < NDUT; d++)
                chk($sformatf("midrst_noack_d%0d_c%0d", d, n), ack_v[d], 1'b0);
            @(negedge clk);
        end
        do_read(ADDR_W'($urandom));

        // Repeat reads of one address, then a neighbour.
        do_read(21'h5);
        do_read(21'h5);
        do_read(21'h6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
